// File: rtl/pattern_serializer_if.sv
// Bus bundle for pattern_serializer: transfer request inputs and serial outputs.
// The master drives the request side; the slave (the serializer) drives the outputs.
interface pattern_serializer_if;
    logic       start;
    logic [7:0] pat;
    logic [2:0] len;
    logic [3:0] rep;
    logic       dout_bit;
    logic       bit_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, pat, len, rep,
        input  dout_bit, bit_valid, busy, done
    );

    modport slave (
        input  start, pat, len, rep,
        output dout_bit, bit_valid, busy, done
    );
endinterface

// File: rtl/pattern_serializer.sv
// Serializes pat[len:0] MSB-first, repeated rep+1 times, with a one-cycle done pulse.
// Optional macro REP_GAP_EN inserts one idle GAP cycle between consecutive passes.
module pattern_serializer (
    input  logic                  clk,
    input  logic                  rst,
    pattern_serializer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_n_s;
    logic [7:0] pat_r;
    logic [7:0] pat_n_s;
    logic [2:0] len_r;
    logic [2:0] len_n_s;
    logic [2:0] idx_r;
    logic [2:0] idx_n_s;
    logic [3:0] rep_r;
    logic [3:0] rep_n_s;

    logic       dout_bit_r;
    logic       bit_valid_r;
    logic       busy_r;
    logic       done_r;
    logic       dout_bit_n_s;
    logic       bit_valid_n_s;
    logic       busy_n_s;
    logic       done_n_s;

    // Next-state, capture and next-output logic; outputs are derived from the next
    // state so that the registered outputs line up with the state they describe.
    always_comb begin
        state_n_s = state_r;
        pat_n_s   = pat_r;
        len_n_s   = len_r;
        idx_n_s   = idx_r;
        rep_n_s   = rep_r;

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_n_s = SHIFT;
                    pat_n_s   = bus.pat;
                    len_n_s   = bus.len;
                    rep_n_s   = bus.rep;
                    idx_n_s   = bus.len;
                end else begin
                    state_n_s = IDLE;
                end
            end
            SHIFT: begin
                if (idx_r == 3'd0) begin
                    if (rep_r == 4'd0) begin
                        state_n_s = DONE;
                    end else begin
                        rep_n_s = rep_r - 4'd1;
                        idx_n_s = len_r;
`ifdef REP_GAP_EN
                        state_n_s = GAP;
`else
                        state_n_s = SHIFT;
`endif
                    end
                end else begin
                    idx_n_s = idx_r - 3'd1;
                end
            end
            // Index was already reloaded on the last bit of the previous pass.
            GAP: begin
                state_n_s = SHIFT;
            end
            DONE: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase

        bit_valid_n_s = (state_n_s == SHIFT);
        busy_n_s      = (state_n_s == SHIFT) || (state_n_s == GAP);
        done_n_s      = (state_n_s == DONE);
        if (bit_valid_n_s) begin
            dout_bit_n_s = pat_n_s[idx_n_s];
        end else begin
            dout_bit_n_s = 1'b0;
        end
    end

    // State, captured transfer parameters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            pat_r       <= 8'd0;
            len_r       <= 3'd0;
            idx_r       <= 3'd0;
            rep_r       <= 4'd0;
            dout_bit_r  <= 1'b0;
            bit_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            pat_r       <= pat_n_s;
            len_r       <= len_n_s;
            idx_r       <= idx_n_s;
            rep_r       <= rep_n_s;
            dout_bit_r  <= dout_bit_n_s;
            bit_valid_r <= bit_valid_n_s;
            busy_r      <= busy_n_s;
            done_r      <= done_n_s;
        end
    end

    assign bus.dout_bit  = dout_bit_r;
    assign bus.bit_valid = bit_valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: a model pushes the expected per-cycle
// outputs {busy, bit_valid, dout_bit, done} when a start is accepted.
module tb_pattern_serializer;

    logic clk;
    logic rst;
    pattern_serializer_if bus ();

    pattern_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];
    logic       chk_en    = 1'b0;
    logic       idle_flag = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected output stream of one transfer, one entry per cycle after capture.
    task automatic push_xfer(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r);
        for (int k = 0; k <= int'(r); k++) begin
            for (int i = int'(l); i >= 0; i--) begin
                exp_q.push_back({1'b1, 1'b1, p[i], 1'b0});
            end
`ifdef REP_GAP_EN
            if (k != int'(r)) exp_q.push_back(4'b1000);
`endif
        end
        exp_q.push_back(4'b0001);
    endtask

    // Model: reset flushes, a start seen while the DUT is idle queues a transfer.
    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            chk_en <= 1'b1;
        end else if (idle_flag && bus.start) begin
            push_xfer(bus.pat, bus.len, bus.rep);
        end
    end

    // Compare every cycle; an empty queue means all outputs must be low.
    always @(negedge clk) begin : checker_blk
        logic [3:0] e;
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                idle_flag <= 1'b0;
            end else begin
                e = 4'b0000;
                idle_flag <= 1'b1;
            end
            check_val("outs", {28'd0, bus.busy, bus.bit_valid, bus.dout_bit, bus.done}, {28'd0, e});
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && idle_flag) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("timeout", (n < 400) ? 32'd0 : 32'd1, 32'd0);
    endtask

    task automatic run_xfer(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r);
        @(negedge clk);
        bus.pat   = p;
        bus.len   = l;
        bus.rep   = r;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.pat   = ~p;
        bus.len   = ~l;
        bus.rep   = ~r;
        wait_idle();
    endtask

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.pat   = 8'd0;
        bus.len   = 3'd0;
        bus.rep   = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer(8'h05, 3'd3, 4'd0);
        run_xfer(8'h02, 3'd1, 4'd2);
        run_xfer(8'h01, 3'd0, 4'd0);

        // start re-pulsed with a different pattern mid-transfer
        @(negedge clk);
        bus.pat = 8'hA5; bus.len = 3'd7; bus.rep = 4'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.pat = 8'h3C; bus.len = 3'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // reset during the third bit, then a full transfer
        @(negedge clk);
        bus.pat = 8'hAA; bus.len = 3'd7; bus.rep = 4'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_xfer(8'hAA, 3'd7, 4'd0);

        // reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b1; bus.pat = 8'hF0; bus.len = 3'd3;
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b0;
        repeat (3) @(negedge clk);

        // start held high through DONE is taken in the following IDLE cycle
        @(negedge clk);
        bus.pat = 8'h06; bus.len = 3'd2; bus.rep = 4'd1; bus.start = 1'b1;
        repeat (12) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        run_xfer(8'hFF, 3'd7, 4'd15);

        for (int t = 0; t < 6; t++) begin
            run_xfer(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
